// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, requests imem, presents instr/pc/pc+2 to decode.
// Fetch data valid the edge after accept; decode stall holds if_* and drops imem_req.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      stateNext;
  logic [15:0] pc;
  logic [15:0] pcPlus2;
  logic [7:0]  waitCnt;
  logic        accept;
  logic        takeRedirect;
  logic        takeHalt;

  assign imem_req     = (state == FETCH) && !(if_valid && stall);
  assign imem_addr    = pc;
  assign halted       = (state == HALTED);
  assign accept       = imem_req && imem_ready;
  assign pcPlus2      = pc + 16'd2;
  assign takeRedirect = redirect && (state != HALTED);
  assign takeHalt     = halt && (state == FETCH) && !takeRedirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = FETCH;
      FETCH:   if (takeHalt) stateNext = HALTED;
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase
    if (takeRedirect) stateNext = FETCH;
  end

  // Redirect and halt both discard a same-cycle accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 16'h0000;
      if_pc       <= 16'h0000;
      if_pc_plus2 <= 16'h0000;
    end else if (takeRedirect) begin
      pc       <= {redirect_pc[15:1], 1'b0};
      if_valid <= 1'b0;
    end else if (takeHalt) begin
      if_valid <= 1'b0;
    end else if (accept) begin
      pc          <= pcPlus2;
      if_valid    <= 1'b1;
      if_instr    <= imem_data;
      if_pc       <= pc;
      if_pc_plus2 <= pcPlus2;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
    end
  end

  // Counter saturates so a long stuck request cannot wrap back below the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= 8'd0;
      err     <= 1'b0;
    end else if (redirect || !imem_req || imem_ready) begin
      waitCnt <= 8'd0;
    end else begin
      if (waitCnt != 8'hFF) waitCnt <= waitCnt + 8'd1;
      if (waitCnt >= TIMEOUT_LAST) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a fetch scoreboard and a wrap-around instance.
module tb_fetch_pc_unit;

  localparam int TIMEOUT_T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        halt;
  logic        stall;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemReady;
  logic [15:0] imemData;
  logic        ifValid;
  logic [15:0] ifInstr;
  logic [15:0] ifPc;
  logic [15:0] ifPcPlus2;
  logic        halted;
  logic        err;
  logic [15:0] dataKey;

  logic        wImemReq;
  logic [15:0] wImemAddr;
  logic [15:0] wImemData;
  logic        wIfValid;
  logic [15:0] wIfInstr;
  logic [15:0] wIfPc;
  logic [15:0] wIfPcPlus2;
  logic        wHalted;
  logic        wErr;

  always #5 clk = ~clk;

  assign imemData  = imemAddr ^ dataKey;
  assign wImemData = wImemAddr;

  fetch_pc_unit #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT_T)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirectPc),
    .halt(halt), .stall(stall), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ready(imemReady), .imem_data(imemData), .if_valid(ifValid),
    .if_instr(ifInstr), .if_pc(ifPc), .if_pc_plus2(ifPcPlus2),
    .halted(halted), .err(err)
  );

  fetch_pc_unit #(.RESET_PC(16'hFFFC), .TIMEOUT(15)) dutWrap (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(16'h0000),
    .halt(1'b0), .stall(1'b0), .imem_req(wImemReq), .imem_addr(wImemAddr),
    .imem_ready(1'b1), .imem_data(wImemData), .if_valid(wIfValid),
    .if_instr(wIfInstr), .if_pc(wIfPc), .if_pc_plus2(wIfPcPlus2),
    .halted(wHalted), .err(wErr)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] plus2;
  } sbEnt_t;

  sbEnt_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] expPc;
  logic        expValid;
  logic [15:0] expInstr;
  logic [15:0] expIfPc;
  logic [15:0] expPlus2;
  logic        expIdle;
  logic        expFetch;
  logic        expHalted;
  logic        expErr;
  int          expCnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle with inputs already driven: check request side, then outputs after the edge.
  task automatic cyc(input string tag);
    logic   req, redir, hlt, rawAcc, acc, hold;
    sbEnt_t e;
    #1;
    req    = expFetch && !(expValid && stall);
    redir  = redirect && !expHalted;
    hlt    = halt && expFetch && !redir;
    rawAcc = req && imemReady;
    acc    = rawAcc && !redir && !hlt;
    hold   = expValid && stall && !redir && !hlt;
    chk({tag, ":req"}, {15'd0, imemReq}, {15'd0, req});
    chk({tag, ":addr"}, imemAddr, expPc);
    if (redirect || !req || rawAcc) expCnt = 0;
    else begin
      expCnt++;
      if (expCnt == TIMEOUT_T) expErr = 1'b1;
    end
    if (acc) begin
      e.pc = expPc;
      e.instr = expPc ^ dataKey;
      e.plus2 = expPc + 16'd2;
      sb.push_back(e);
      expPc = expPc + 16'd2;
    end
    if (redir) begin
      expPc = {redirectPc[15:1], 1'b0};
      expFetch = 1'b1;
      expIdle = 1'b0;
    end else if (hlt) begin
      expFetch = 1'b0;
      expHalted = 1'b1;
    end else if (expIdle) begin
      expIdle = 1'b0;
      expFetch = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      expValid = 1'b1;
      expIfPc = e.pc;
      expInstr = e.instr;
      expPlus2 = e.plus2;
    end else if (!hold) begin
      expValid = 1'b0;
    end
    chk({tag, ":valid"}, {15'd0, ifValid}, {15'd0, expValid});
    if (expValid) begin
      chk({tag, ":if_pc"}, ifPc, expIfPc);
      chk({tag, ":if_instr"}, ifInstr, expInstr);
      chk({tag, ":if_pc_plus2"}, ifPcPlus2, expPlus2);
    end
    chk({tag, ":halted"}, {15'd0, halted}, {15'd0, expHalted});
    chk({tag, ":err"}, {15'd0, err}, {15'd0, expErr});
  endtask

  initial begin
    logic [15:0] wExp;
    int guard;
    rst = 1'b1;
    redirect = 1'b0;
    redirectPc = 16'h0000;
    halt = 1'b0;
    stall = 1'b0;
    imemReady = 1'b1;
    dataKey = 16'h0000;
    expPc = 16'h0000;
    expValid = 1'b0;
    expInstr = 16'h0000;
    expIfPc = 16'h0000;
    expPlus2 = 16'h0000;
    expIdle = 1'b1;
    expFetch = 1'b0;
    expHalted = 1'b0;
    expErr = 1'b0;
    expCnt = 0;

    @(posedge clk);
    #1;
    chk("rst:req", {15'd0, imemReq}, 16'd0);
    chk("rst:addr", imemAddr, 16'h0000);
    chk("rst:valid", {15'd0, ifValid}, 16'd0);
    chk("rst:if_instr", ifInstr, 16'h0000);
    chk("rst:if_pc", ifPc, 16'h0000);
    chk("rst:if_pc_plus2", ifPcPlus2, 16'h0000);
    chk("rst:halted", {15'd0, halted}, 16'd0);
    chk("rst:err", {15'd0, err}, 16'd0);
    chk("rst:wrap_addr", wImemAddr, 16'hFFFC);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential fetch from 0 (data = address) and from FFFC through the wrap.
    cyc("idle");
    for (int i = 0; i < 4; i++) begin
      cyc("seq");
      chk("seq:pc_const", ifPc, 16'(2 * i));
      wExp = 16'hFFFC + 16'(2 * i);
      chk("wrap:valid", {15'd0, wIfValid}, 16'd1);
      chk("wrap:if_pc", wIfPc, wExp);
      chk("wrap:if_instr", wIfInstr, wExp);
      chk("wrap:if_pc_plus2", wIfPcPlus2, wExp + 16'd2);
    end

    // Decode stall for three cycles, then resume.
    dataKey = 16'h5A5A;
    stall = 1'b1;
    repeat (3) cyc("stall");
    chk("stall:held_pc", ifPc, 16'h0006);
    stall = 1'b0;
    cyc("unstall");
    chk("unstall:next_pc", ifPc, 16'h0008);

    // Redirect coincident with the accept at 0x0010.
    guard = 0;
    while (expPc != 16'h0010 && guard < 16) begin
      cyc("run");
      guard++;
    end
    chk("redir:reached_0010", expPc, 16'h0010);
    redirect = 1'b1;
    redirectPc = 16'h1235;
    cyc("redir");
    redirect = 1'b0;
    chk("redir:valid_drop", {15'd0, ifValid}, 16'd0);
    cyc("post_redir");
    chk("redir:new_pc", ifPc, 16'h1234);
    cyc("post_redir");

    // Memory stops answering long enough to trip the timeout.
    imemReady = 1'b0;
    repeat (3) cyc("wait");
    chk("timeout:err_before", {15'd0, err}, 16'd0);
    cyc("wait");
    chk("timeout:err_set", {15'd0, err}, 16'd1);
    imemReady = 1'b1;
    repeat (3) cyc("resume");
    chk("timeout:err_sticky", {15'd0, err}, 16'd1);

    // Halt, then a redirect that must be ignored.
    halt = 1'b1;
    cyc("halt");
    halt = 1'b0;
    chk("halt:halted", {15'd0, halted}, 16'd1);
    repeat (2) cyc("halted");
    redirect = 1'b1;
    redirectPc = 16'h4000;
    cyc("halt_redir");
    redirect = 1'b0;
    repeat (2) cyc("halted");
    chk("halt:req_low", {15'd0, imemReq}, 16'd0);
    chk("halt:err_before_rst", {15'd0, err}, 16'd1);

    // Asynchronous reset in the middle of a cycle.
    #3;
    rst = 1'b1;
    #1;
    chk("arst:halted", {15'd0, halted}, 16'd0);
    chk("arst:err", {15'd0, err}, 16'd0);
    chk("arst:valid", {15'd0, ifValid}, 16'd0);
    chk("arst:req", {15'd0, imemReq}, 16'd0);
    chk("arst:addr", imemAddr, 16'h0000);
    chk("arst:wrap_addr", wImemAddr, 16'hFFFC);
    #10;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
